// File: rtl/hvac_pkg.sv
// Shared types and default timing for the HVAC sequencer slice.
package hvac_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HEAT, ST_COOL, ST_REST} state_t;
  typedef enum logic [1:0] {MODE_NONE, MODE_HEAT, MODE_COOL} mode_t;

  localparam int DEF_MIN_ON    = 8;
  localparam int DEF_MIN_OFF   = 6;
  localparam int DEF_DEAD_TIME = 4;
  localparam int DEF_FAN_RUNON = 3;
  localparam int DEF_COUNT_W   = 8;

endpackage

// File: rtl/hvac_timer.sv
// Saturating up-counter with synchronous clear, used for on-time and rest-time.
module hvac_timer
  import hvac_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int LIMIT   = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COUNT_W-1:0] cnt
);

  localparam logic [COUNT_W-1:0] LIM = COUNT_W'(LIMIT);

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt < LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hvac_sequencer.sv
// Heat/cool plant sequencer: minimum on/off times, changeover dead-time,
// fan run-on and a conflicting-request flag.
module hvac_sequencer
  import hvac_pkg::*;
#(
  parameter int MIN_ON    = DEF_MIN_ON,
  parameter int MIN_OFF   = DEF_MIN_OFF,
  parameter int DEAD_TIME = DEF_DEAD_TIME,
  parameter int FAN_RUNON = DEF_FAN_RUNON,
  parameter int COUNT_W   = DEF_COUNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic heat_req,
  input  logic cool_req,
  output logic heat_en,
  output logic cool_en,
  output logic fan_en,
  output logic fault
);

  localparam logic [COUNT_W-1:0] ON_LIM       = COUNT_W'(MIN_ON);
  localparam logic [COUNT_W-1:0] OFF_LIM      = COUNT_W'(MIN_OFF);
  localparam logic [COUNT_W-1:0] OFF_DEAD_LIM = COUNT_W'(MIN_OFF + DEAD_TIME);
  localparam logic [COUNT_W-1:0] RUNON_LIM    = COUNT_W'(FAN_RUNON);

  state_t             state, next_state;
  mode_t              last_mode;
  logic [COUNT_W-1:0] on_cnt, rest_cnt;
  logic               heat_v, cool_v, heat_ok, cool_ok, run_next;

  assign heat_v   = heat_req & ~cool_req;
  assign cool_v   = cool_req & ~heat_req;
  // A changeover is allowed only once rest time covers MIN_OFF + DEAD_TIME.
  assign heat_ok  = heat_v && ((last_mode != MODE_COOL) || (rest_cnt >= OFF_DEAD_LIM));
  assign cool_ok  = cool_v && ((last_mode != MODE_HEAT) || (rest_cnt >= OFF_DEAD_LIM));
  assign run_next = (next_state == ST_HEAT) || (next_state == ST_COOL);

  // on_cnt = cycles the current run has lasted; rest_cnt = cycles since the
  // last run ended (keeps counting through IDLE, held at zero while running).
  hvac_timer #(.COUNT_W(COUNT_W), .LIMIT(MIN_ON)) u_on_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~run_next),
    .en    (1'b1),
    .cnt   (on_cnt)
  );

  hvac_timer #(.COUNT_W(COUNT_W), .LIMIT(MIN_OFF + DEAD_TIME)) u_rest_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_next),
    .en    (1'b1),
    .cnt   (rest_cnt)
  );

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (heat_ok)      next_state = ST_HEAT;
        else if (cool_ok) next_state = ST_COOL;
      end
      ST_HEAT: if (!heat_v && (on_cnt >= ON_LIM)) next_state = ST_REST;
      ST_COOL: if (!cool_v && (on_cnt >= ON_LIM)) next_state = ST_REST;
      ST_REST: begin
        if (rest_cnt >= OFF_LIM) begin
          if (heat_ok)                next_state = ST_HEAT;
          else if (cool_ok)           next_state = ST_COOL;
          else if (!(heat_v | cool_v)) next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_mode <= MODE_NONE;
      heat_en   <= 1'b0;
      cool_en   <= 1'b0;
      fan_en    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state   <= next_state;
      heat_en <= (next_state == ST_HEAT);
      cool_en <= (next_state == ST_COOL);
      fan_en  <= run_next || ((next_state == ST_REST) && (rest_cnt < RUNON_LIM));
      fault   <= heat_req & cool_req;
      if ((next_state == ST_REST) && (state != ST_REST)) begin
        last_mode <= (state == ST_HEAT) ? MODE_HEAT : MODE_COOL;
      end
    end
  end

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer with default timing (8/6/4/3).
module tb_hvac_sequencer;
  import hvac_pkg::*;

  logic clk = 1'b0;
  logic rst_n, heat_req, cool_req;
  logic heat_en, cool_en, fan_en, fault;
  int   n_tests = 0;
  int   n_fail  = 0;

  hvac_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .heat_req (heat_req),
    .cool_req (cool_req),
    .heat_en  (heat_en),
    .cool_en  (cool_en),
    .fan_en   (fan_en),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; heat_req = 1'b0; cool_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; heat_req = 1'b1; cool_req = 1'b0;
    tick(); tick();
    n_tests++;
    if ({heat_en, cool_en, fan_en, fault} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=0000", {heat_en, cool_en, fan_en, fault});
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (heat_en !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_heat got=%b exp=1", heat_en);
    end
    n_tests++;
    if (dut.state !== ST_HEAT) begin
      n_fail++; $display("FAIL reset_release_state got=%0d exp=%0d", dut.state, ST_HEAT);
    end
  endtask

  task automatic test_min_on();
    int heat_cnt = 0, fan_cnt = 0, fall_c = -1, idle_c = -1;
    logic prev = 1'b0;
    do_reset();
    heat_req = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 2) heat_req = 1'b0;
      heat_cnt += int'(heat_en);
      fan_cnt  += int'(fan_en);
      if (prev && !heat_en && fall_c < 0) fall_c = c;
      if (fall_c >= 0 && idle_c < 0 && dut.state == ST_IDLE) idle_c = c;
      prev = heat_en;
    end
    n_tests++;
    if (heat_cnt !== 8) begin n_fail++; $display("FAIL min_on_heat_cycles got=%0d exp=8", heat_cnt); end
    n_tests++;
    if (fan_cnt !== 11) begin n_fail++; $display("FAIL min_on_fan_cycles got=%0d exp=11", fan_cnt); end
    n_tests++;
    if (fall_c !== 9) begin n_fail++; $display("FAIL min_on_fall_cycle got=%0d exp=9", fall_c); end
    n_tests++;
    if (idle_c - fall_c !== 6) begin n_fail++; $display("FAIL min_on_idle_delay got=%0d exp=6", idle_c - fall_c); end
  endtask

  task automatic test_changeover();
    int heat_cnt = 0, fall_c = -1, rise_c = -1, bad = 0;
    logic prev = 1'b0;
    do_reset();
    heat_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 10) begin heat_req = 1'b0; cool_req = 1'b1; end
      heat_cnt += int'(heat_en);
      if (prev && !heat_en && fall_c < 0) fall_c = c;
      if (fall_c >= 0 && heat_en) bad++;
      if (heat_en && cool_en) bad++;
      if (cool_en && rise_c < 0) rise_c = c;
      prev = heat_en;
    end
    cool_req = 1'b0;
    n_tests++;
    if (heat_cnt !== 10) begin n_fail++; $display("FAIL chg_heat_cycles got=%0d exp=10", heat_cnt); end
    n_tests++;
    if (rise_c - fall_c !== 10) begin n_fail++; $display("FAIL chg_dead_time got=%0d exp=10", rise_c - fall_c); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL chg_heat_off got=%0d exp=0", bad); end
  endtask

  task automatic test_idle_dead_time();
    int fall_c = -1, rise_c = -1;
    logic prev = 1'b0;
    logic idle_seen = 1'b0;
    do_reset();
    heat_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) heat_req = 1'b0;
      if (prev && !heat_en && fall_c < 0) fall_c = c;
      if (fall_c > 0 && c == fall_c + 7) begin
        idle_seen = (dut.state == ST_IDLE);
        cool_req = 1'b1;
      end
      if (cool_en && rise_c < 0) rise_c = c;
      prev = heat_en;
    end
    cool_req = 1'b0;
    n_tests++;
    if (idle_seen !== 1'b1) begin n_fail++; $display("FAIL idle_dead_in_idle got=%b exp=1", idle_seen); end
    n_tests++;
    if (rise_c - fall_c !== 10) begin n_fail++; $display("FAIL idle_dead_delay got=%0d exp=10", rise_c - fall_c); end
  endtask

  task automatic test_same_restart();
    int fall_c = -1, rise_c = -1;
    logic prev = 1'b0;
    do_reset();
    heat_req = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 1) heat_req = 1'b0;
      if (prev && !heat_en && fall_c < 0) begin fall_c = c; heat_req = 1'b1; end
      if (fall_c >= 0 && heat_en && rise_c < 0) rise_c = c;
      prev = heat_en;
    end
    heat_req = 1'b0;
    n_tests++;
    if (rise_c - fall_c !== 6) begin n_fail++; $display("FAIL restart_delay got=%0d exp=6", rise_c - fall_c); end
  endtask

  task automatic test_conflict();
    do_reset();
    n_tests++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL conflict_pre_fault got=%b exp=0", fault); end
    heat_req = 1'b1; cool_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 3) begin heat_req = 1'b0; cool_req = 1'b0; end
      n_tests++;
      if (fault !== (c <= 3)) begin
        n_fail++; $display("FAIL conflict_fault c=%0d got=%b exp=%b", c, fault, (c <= 3));
      end
      n_tests++;
      if ({heat_en, cool_en, fan_en} !== 3'b000) begin
        n_fail++; $display("FAIL conflict_enables c=%0d got=%b exp=000", c, {heat_en, cool_en, fan_en});
      end
    end
  endtask

  task automatic test_cool_conflict();
    do_reset();
    cool_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 8) begin
        heat_req = 1'b1;
        n_tests++;
        if (cool_en !== 1'b1) begin n_fail++; $display("FAIL cool_conf_on got=%b exp=1", cool_en); end
      end
    end
    n_tests++;
    if (cool_en !== 1'b0) begin n_fail++; $display("FAIL cool_conf_off got=%b exp=0", cool_en); end
    n_tests++;
    if (fault !== 1'b1) begin n_fail++; $display("FAIL cool_conf_fault got=%b exp=1", fault); end
    n_tests++;
    if (heat_en !== 1'b0) begin n_fail++; $display("FAIL cool_conf_heat got=%b exp=0", heat_en); end
    heat_req = 1'b0; cool_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    cool_req = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({cool_en, fan_en} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_outputs got=%b exp=00", {cool_en, fan_en});
    end
    rst_n = 1'b1; cool_req = 1'b0; heat_req = 1'b1;
    tick();
    n_tests++;
    if (heat_en !== 1'b1) begin n_fail++; $display("FAIL mid_reset_heat got=%b exp=1", heat_en); end
    n_tests++;
    if (cool_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_cool got=%b exp=0", cool_en); end
    heat_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; heat_req = 1'b0; cool_req = 1'b0;
    test_reset();
    test_min_on();
    test_changeover();
    test_idle_dead_time();
    test_same_restart();
    test_conflict();
    test_cool_conflict();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hvac_sequencer.md
HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter MIN_ON, default 8, SHALL set the minimum cycles heat_en/cool_en stay high once asserted.
REQ-003 Parameter MIN_OFF, default 6, SHALL set the minimum cycles in REST after any run.
REQ-004 Parameter DEAD_TIME, default 4, SHALL set the extra REST cycles on heat<->cool changeover.
REQ-005 Parameter FAN_RUNON, default 3, SHALL set the fan run-on cycles after a run ends; FAN_RUNON <= MIN_OFF.
REQ-006 Parameter COUNT_W, default 8, SHALL set the counter width; all timing parameters, and MIN_OFF+DEAD_TIME, fit in COUNT_W bits.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port rst_n, input, 1: synchronous active-low reset.
REQ-009 Port heat_req, input, 1: heating demand from the thermostat (heater block).
REQ-010 Port cool_req, input, 1: cooling demand from the thermostat.
REQ-011 Port heat_en, output, 1: heating plant enable, registered.
REQ-012 Port cool_en, output, 1: cooling plant enable, registered.
REQ-013 Port fan_en, output, 1: circulation fan enable, registered.
REQ-014 Port fault, output, 1: registered flag, high one cycle after any cycle with heat_req and cool_req both sampled high.

Function
REQ-015 The FSM SHALL have states IDLE, HEAT, COOL and REST; heat_en = (state==HEAT) and cool_en = (state==COOL), so heat_en and cool_en are never high together.
REQ-016 A request SHALL be valid only when exactly one of heat_req/cool_req is high; both high counts as no request.
REQ-017 In IDLE, a valid heat (cool) request sampled at edge N SHALL move the FSM to HEAT (COOL), with the enable high from edge N onward (one-cycle latency).
REQ-018 In HEAT/COOL, the on-counter SHALL count cycles from entry and saturate at MIN_ON.
REQ-019 HEAT/COOL SHALL exit to REST at the first edge where the matching valid request is absent and the on-counter has reached MIN_ON; an early request drop SHALL extend the run to exactly MIN_ON cycles.
REQ-020 On entry to REST, the last_mode register SHALL record HEAT or COOL, and the rest-counter SHALL clear.
REQ-021 fan_en SHALL be high in HEAT, in COOL, and during the first FAN_RUNON cycles of REST; otherwise low.
REQ-022 Once the rest-counter reaches MIN_OFF, REST SHALL exit as follows:
- same-mode valid request: go directly to that mode;
- no request: go to IDLE;
- opposite-mode request: stay in REST until the rest-counter reaches MIN_OFF+DEAD_TIME, then go to the opposite mode if the request is still valid, else IDLE.
REQ-023 From IDLE, an opposite-mode request SHALL wait only the remaining time needed to meet MIN_OFF+DEAD_TIME after the last run; last_mode persists in IDLE until reset.
REQ-024 fault SHALL not latch; it SHALL follow (heat_req & cool_req) delayed by one cycle in every state.

Reset
REQ-025 When rst_n=0 at an edge, in any state including mid-run, the block SHALL apply the following at that edge:
- state = IDLE;
- heat_en, cool_en, fan_en and fault = 0;
- counters = 0;
- last_mode = NONE, so no changeover dead-time is applied after reset.
REQ-026 The first edge with rst_n=1 SHALL evaluate requests as IDLE.

Structure
REQ-027 Package hvac_pkg SHALL hold:
- the state enum (IDLE, HEAT, COOL, REST);
- the mode enum (NONE, HEAT, COOL);
- the default timing constants.
REQ-028 The counters SHALL use one sub-module, hvac_timer: a COUNT_W up-counter with synchronous clear and saturation, instantiated for the on-count and the rest-count.

Verification
REQ-029 Reset: heat_req=1 with rst_n=0 for 2 edges -> all outputs 0; then rst_n=1 -> heat_en=1 after the first edge.
REQ-030 Minimum-on: heat_req high for 2 cycles from IDLE -> heat_en high exactly 8 cycles, fan_en high 11 cycles, IDLE reached 6 cycles after heat_en falls.
REQ-031 Changeover: heat run of 10 cycles, then cool_req held high -> cool_en rises exactly 10 cycles after heat_en falls, with heat_en=0 throughout.
REQ-032 Same-mode restart: heat_req re-asserted when heat_en falls -> heat_en rises exactly 6 cycles later.
REQ-033 Conflict:
- both requests high for 3 cycles in IDLE -> fault high 3 cycles, delayed 1 cycle, with no enables;
- both high in COOL after 8 cycles -> cool_en falls at the next edge.
REQ-034 Mid-run reset: rst_n=0 on cycle 3 of COOL -> cool_en and fan_en low after that edge; a later heat_req after release sees no dead-time.
